// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Brief    : Shared widths, idle code and FSM encodings for the DAC TX channel
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;
    localparam int DAC_W = 12;
    localparam logic [DAC_W-1:0] DEF_IDLE_CODE = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } dac_state_e;
endpackage
`default_nettype wire

// File: rtl/dac_channel_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock show-ahead FIFO with registered count and flush
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Flush wins over a push in the same cycle, so that word is dropped.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/dac_channel_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_channel_tx
// Brief    : Primed FIFO streaming 24-bit words onto a 12-bit DDR LVDS DAC bus
// Revision : 1.0 - initial release
// ============================================================================
module dac_channel_tx
    import dac_pkg::*;
#(
    parameter int               FIFO_DEPTH  = 16,
    parameter int               PRIME_LEVEL = 8,
    parameter logic [DAC_W-1:0] IDLE_CODE   = DEF_IDLE_CODE
) (
    input  logic                 dac_clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [2*DAC_W-1:0]   s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [DAC_W-1:0]     data_p_o,
    output logic [DAC_W-1:0]     data_n_o,
    output logic                 dci_p_o,
    output logic                 dci_n_o,
    output logic                 underrun_o,
    output logic [15:0]          underrun_cnt_o,
    output logic [1:0]           state_o
);
    localparam int                 CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]      DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]      PRIME_C   = CW'(PRIME_LEVEL);
    localparam logic [2*DAC_W-1:0] IDLE_WORD = {IDLE_CODE, IDLE_CODE};

    dac_state_e          r_state;
    dac_state_e          w_state_nxt;
    logic [CW-1:0]       w_count;
    logic [2*DAC_W-1:0]  w_fifo_rdata;
    logic [2*DAC_W-1:0]  r_out_q;
    logic                w_empty;
    logic                w_flush;
    logic                w_push;
    logic                w_pop;
    logic                w_underrun_entry;
    logic                r_underrun;
    logic [15:0]         r_underrun_cnt;
    logic                r_dci_d1;
    logic                r_dci_d2;
    logic                w_dci_q;

    assign w_empty   = (w_count == '0);
    assign s_ready_o = (r_state != ST_IDLE) && (w_count < DEPTH_C);
    assign w_push    = s_valid_i && s_ready_o;
    assign w_pop     = en_i && (r_state == ST_RUN) && !w_empty;
    assign w_flush   = !en_i || (r_state == ST_IDLE);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*DAC_W)
    ) u_fifo (
        .clk     (dac_clk_i),
        .rst     (rst_i),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (s_data_i),
        .o_rdata (w_fifo_rdata),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_underrun_entry = 1'b0;
        if (!en_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:               w_state_nxt = ST_PRIME;
                ST_PRIME, ST_UNDERRUN: if (w_count >= PRIME_C) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_empty) begin
                        w_state_nxt      = ST_UNDERRUN;
                        w_underrun_entry = 1'b1;
                    end
                end
                default:               w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dac_clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_out_q        <= IDLE_WORD;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_q    <= w_pop ? w_fifo_rdata : IDLE_WORD;
            r_underrun <= w_underrun_entry;
            if (w_underrun_entry && (r_underrun_cnt != 16'hFFFF))
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    // Same-edge DDR register: both halves captured on the rising edge,
    // rise half presented while the clock is high, fall half while low.
    genvar gi;
    generate
        for (gi = 0; gi < DAC_W; gi++) begin : g_data_oddr
            logic r_d1;
            logic r_d2;
            logic w_q;
            always_ff @(posedge dac_clk_i) begin
                if (rst_i) begin
                    r_d1 <= IDLE_CODE[gi];
                    r_d2 <= IDLE_CODE[gi];
                end else begin
                    r_d1 <= r_out_q[DAC_W+gi];
                    r_d2 <= r_out_q[gi];
                end
            end
            assign w_q         = dac_clk_i ? r_d1 : r_d2;
            assign data_p_o[gi] = w_q;
            assign data_n_o[gi] = ~w_q;
        end
    endgenerate

    always_ff @(posedge dac_clk_i) begin
        if (rst_i) begin
            r_dci_d1 <= 1'b0;
            r_dci_d2 <= 1'b0;
        end else begin
            r_dci_d1 <= 1'b1;
            r_dci_d2 <= 1'b0;
        end
    end

    assign w_dci_q        = dac_clk_i ? r_dci_d1 : r_dci_d2;
    assign dci_p_o        = w_dci_q;
    assign dci_n_o        = ~w_dci_q;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;
    assign state_o        = r_state;
endmodule
`default_nettype wire

// File: tb/tb_dac_channel_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_channel_tx
// Brief    : Self-checking bench: vector table, queue reference model, streams
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_channel_tx;
    localparam logic [11:0] IDLE   = 12'h800;
    localparam logic [23:0] IDLE_W = 24'h800800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b0, valid = 1'b0;
    logic [23:0] data = 24'd0;
    logic        s_ready, dci_p, dci_n, underrun;
    logic [11:0] data_p, data_n;
    logic [15:0] ucnt;
    logic [1:0]  state_o;

    logic        en2 = 1'b0, valid2 = 1'b0;
    logic [23:0] data2 = 24'd0;
    logic        s_ready2, dci_p2, dci_n2, underrun2;
    logic [11:0] data_p2, data_n2;
    logic [15:0] ucnt2;
    logic [1:0]  state2;

    dac_channel_tx dut (
        .dac_clk_i(clk), .rst_i(rst), .en_i(en), .s_data_i(data), .s_valid_i(valid),
        .s_ready_o(s_ready), .data_p_o(data_p), .data_n_o(data_n), .dci_p_o(dci_p),
        .dci_n_o(dci_n), .underrun_o(underrun), .underrun_cnt_o(ucnt), .state_o(state_o)
    );

    dac_channel_tx #(.FIFO_DEPTH(16), .PRIME_LEVEL(16)) dut2 (
        .dac_clk_i(clk), .rst_i(rst), .en_i(en2), .s_data_i(data2), .s_valid_i(valid2),
        .s_ready_o(s_ready2), .data_p_o(data_p2), .data_n_o(data_n2), .dci_p_o(dci_p2),
        .dci_n_o(dci_n2), .underrun_o(underrun2), .underrun_cnt_o(ucnt2), .state_o(state2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, mode numbers from the state table.
    logic [23:0] m_q[$];
    int          m_st = 0;
    logic [23:0] m_out = IDLE_W;
    logic [11:0] m_rise = IDLE, m_fall = IDLE;
    logic        m_upulse = 1'b0;
    logic        m_dci = 1'b0;
    int          m_ucnt = 0;

    task automatic model_step(input logic r, input logic e, input logic v, input logic [23:0] d);
        int          sz;
        bit          rdy;
        int          nst;
        logic [23:0] nxt_out;
        if (r) begin
            m_q.delete();
            m_st = 0; m_out = IDLE_W; m_rise = IDLE; m_fall = IDLE;
            m_upulse = 1'b0; m_ucnt = 0; m_dci = 1'b0;
            return;
        end
        sz = m_q.size();
        m_dci  = 1'b1;
        m_rise = m_out[23:12];
        m_fall = m_out[11:0];
        if (!e) begin
            m_q.delete();
            m_st = 0; m_out = IDLE_W; m_upulse = 1'b0;
            return;
        end
        rdy      = (m_st != 0) && (sz < 16);
        nst      = m_st;
        nxt_out  = IDLE_W;
        m_upulse = 1'b0;
        case (m_st)
            0:       nst = 1;
            1, 3:    if (sz >= 8) nst = 2;
            default: begin
                if (sz == 0) begin
                    nst = 3;
                    m_upulse = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                end else begin
                    nxt_out = m_q.pop_front();
                end
            end
        endcase
        if (rdy && v) m_q.push_back(d);
        m_st  = nst;
        m_out = nxt_out;
    endtask

    logic [11:0] hi1, hi2, lo2;
    bit          cap2 = 1'b0;
    logic [23:0] rcv2[$];
    logic [23:0] sent2[$];

    // One clock: model advances on the edge; DUT is sampled in both phases.
    task automatic cycle();
        logic r_s, e_s, v_s;
        logic [23:0] d_s;
        logic [11:0] exp_n;
        r_s = rst; e_s = en; v_s = valid; d_s = data;
        @(posedge clk);
        model_step(r_s, e_s, v_s, d_s);
        #1;
        hi1 = data_p;
        hi2 = data_p2;
        chk("state", {30'd0, state_o}, m_st);
        chk("ready", {31'd0, s_ready}, {31'd0, (m_st != 0) && (m_q.size() < 16)});
        chk("underrun", {31'd0, underrun}, {31'd0, m_upulse});
        chk("ucnt", {16'd0, ucnt}, m_ucnt);
        chk("pin_p_rise", {20'd0, data_p}, {20'd0, m_rise});
        exp_n = ~m_rise;
        chk("pin_n_rise", {20'd0, data_n}, {20'd0, exp_n});
        chk("dci_rise", {30'd0, dci_p, dci_n}, {30'd0, m_dci, ~m_dci});
        @(negedge clk);
        #1;
        lo2 = data_p2;
        chk("pin_p_fall", {20'd0, data_p}, {20'd0, m_fall});
        exp_n = ~m_fall;
        chk("pin_n_fall", {20'd0, data_n}, {20'd0, exp_n});
        chk("dci_fall", {30'd0, dci_p, dci_n}, 32'd1);
        if (cap2 && ({hi2, lo2} != IDLE_W)) rcv2.push_back({hi2, lo2});
    endtask

    int k2 = 1;

    function automatic logic [23:0] w2(input int k);
        logic [11:0] a;
        a = k[11:0];
        return {a, ~a};
    endfunction

    function automatic logic [23:0] wk(input int i);
        logic [11:0] a, b;
        a = 12'(2 * i + 1);
        b = 12'(2 * i + 2);
        return {a, b};
    endfunction

    task automatic push2_step();
        bit acc;
        acc = valid2 && s_ready2;
        cycle();
        if (acc) begin
            sent2.push_back(data2);
            k2++;
            data2 = w2(k2);
        end
    endtask

    task automatic wait_st(input int want, input string nm);
        for (int g = 0; g < 60 && m_st != want; g++) cycle();
        chk(nm, {30'd0, state_o}, want);
    endtask

    typedef struct {
        logic        r, e, v;
        logic [23:0] d;
        logic [1:0]  st;
        logic        rdy, ur;
        logic [15:0] cnt;
        logic [11:0] rise;
    } vec_t;
    vec_t tbl[21];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 24'd0, 2'd0, 1'b0, 1'b0, 16'd0, 12'h800};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 24'd0, 2'd1, 1'b1, 1'b0, 16'd0, 12'h800};
        for (int k = 2; k <= 9; k++)
            tbl[k] = '{1'b0, 1'b1, 1'b1, wk(k - 2), 2'd1, 1'b1, 1'b0, 16'd0, 12'h800};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 24'd0, 2'd2, 1'b1, 1'b0, 16'd0, 12'h800};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 24'd0, 2'd2, 1'b1, 1'b0, 16'd0, 12'h800};
        for (int k = 12; k <= 18; k++)
            tbl[k] = '{1'b0, 1'b1, 1'b0, 24'd0, 2'd2, 1'b1, 1'b0, 16'd0, 12'(2 * (k - 12) + 1)};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 24'd0, 2'd3, 1'b1, 1'b1, 16'd1, 12'h00F};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 24'd0, 2'd3, 1'b1, 1'b0, 16'd1, 12'h800};

        // Directed prime / stream / underrun sequence.
        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].r; en = tbl[i].e; valid = tbl[i].v; data = tbl[i].d;
            cycle();
            chk($sformatf("tbl%0d_state", i), {30'd0, state_o}, {30'd0, tbl[i].st});
            chk($sformatf("tbl%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_urun", i), {31'd0, underrun}, {31'd0, tbl[i].ur});
            chk($sformatf("tbl%0d_ucnt", i), {16'd0, ucnt}, {16'd0, tbl[i].cnt});
            chk($sformatf("tbl%0d_rise", i), {20'd0, hi1}, {20'd0, tbl[i].rise});
        end

        // Resume after underrun, then fast-forward the event counter to saturation.
        force dut.r_underrun_cnt = 16'hFFFA;
        #1;
        release dut.r_underrun_cnt;
        m_ucnt = 16'hFFFA;
        for (int u = 0; u < 11; u++) begin
            valid = 1'b1;
            data  = $urandom;
            for (int g = 0; g < 60 && m_st != 2; g++) begin
                data = $urandom;
                cycle();
            end
            chk("resume_run", {30'd0, state_o}, 32'd2);
            valid = 1'b0;
            wait_st(3, "drain_underrun");
        end
        chk("ucnt_saturated", {16'd0, ucnt}, 32'h0000FFFF);

        // Randomised traffic with enable drops and one mid-stream reset.
        en = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            int dens;
            dens = $urandom_range(30, 100);
            for (int c = 0; c < 200; c++) begin
                valid = ($urandom_range(0, 99) < dens);
                data  = $urandom;
                rst   = (blk == 7 && c == 100);
                if ($urandom_range(0, 299) == 0) en = 1'b0;
                else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
                cycle();
            end
        end
        rst = 1'b0;

        // Deep-prime instance: backpressure at full, 1000-word integrity.
        en = 1'b0; valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        cap2 = 1'b1;
        en2 = 1'b1; valid2 = 1'b0;
        cycle();
        valid2 = 1'b1; k2 = 1; data2 = w2(k2);
        for (int j = 0; j < 26; j++) begin
            chk($sformatf("fill_ready_%0d", j), {31'd0, s_ready2}, {31'd0, (j < 16 || j >= 18)});
            if (j == 17) chk("full_run_state", {30'd0, state2}, 32'd2);
            push2_step();
        end
        for (int g = 0; g < 1500 && sent2.size() < 1000; g++) push2_step();
        valid2 = 1'b0;
        repeat (40) cycle();
        chk("stream_count", rcv2.size(), sent2.size());
        for (int i = 0; i < sent2.size() && i < rcv2.size(); i++) begin
            chk($sformatf("stream_word_%0d", i), {8'd0, rcv2[i]}, {8'd0, sent2[i]});
            if (rcv2[i] !== sent2[i]) break;
        end
        chk("stream_one_underrun", {16'd0, ucnt2}, 32'd1);

        // Enable drop with a full FIFO mid-stream.
        cap2 = 1'b0;
        valid2 = 1'b1;
        repeat (30) push2_step();
        en2 = 1'b0;
        cycle();
        chk("drop_state", {30'd0, state2}, 32'd0);
        chk("drop_ready", {31'd0, s_ready2}, 32'd0);
        cycle();
        chk("drop_pin_rise", {20'd0, hi2}, {20'd0, IDLE});
        chk("drop_pin_fall", {20'd0, lo2}, {20'd0, IDLE});
        en2 = 1'b1; valid2 = 1'b0;
        repeat (20) cycle();
        chk("drop_flushed", {30'd0, state2}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
